// File: rtl/gen_arb2.sv
// gen_arb2: two-requester arbiter in front of one shared streaming generator.
// Round-robin grant, one-cycle launch, combinational routing while streaming,
// and a one-cycle generator reset on abort.
// Optional feature: define GEN_ARB2_WATCHDOG_EN to add an 8-bit stall watchdog
// that aborts a stuck stream and raises a sticky err flag.
module gen_arb2 (
    input  logic               __clock,
    input  logic               __reset,
    input  logic               r0_req,
    input  logic               r1_req,
    input  logic signed [31:0] r0_n,
    input  logic signed [31:0] r1_n,
    input  logic               r0_ready,
    input  logic               r1_ready,
    output logic               r0_valid,
    output logic               r0_done,
    output logic               r1_valid,
    output logic               r1_done,
    output logic signed [31:0] r0_output_0,
    output logic signed [31:0] r1_output_0,
    output logic signed [31:0] g_n,
    output logic               g_start,
    output logic               g_reset,
    output logic               g_ready,
    input  logic               g_valid,
    input  logic               g_done,
    input  logic signed [31:0] g_output_0,
    output logic [1:0]         grant,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, ABORT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    // 1 means r1 was served last, so r0 is favoured on a tie.
    logic        last_q, last_d;

    logic               sel_req;
    logic               sel_ready;
    logic signed [31:0] sel_n;
    logic               streaming;
    logic               xfer;

`ifdef GEN_ARB2_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    // Pick the owner's request, ready and argument.
    always_comb begin
        sel_req   = 1'b0;
        sel_ready = 1'b0;
        sel_n     = '0;
        if (grant_q[0]) begin
            sel_req   = r0_req;
            sel_ready = r0_ready;
            sel_n     = r0_n;
        end else if (grant_q[1]) begin
            sel_req   = r1_req;
            sel_ready = r1_ready;
            sel_n     = r1_n;
        end
    end

    // Generator-facing and requester-facing outputs; everything is silenced during reset.
    always_comb begin
        streaming   = (state_q == STREAM) && !__reset;
        g_start     = (state_q == LAUNCH) && !__reset;
        g_ready     = streaming && sel_ready;
        g_reset     = __reset || (state_q == ABORT);
        g_n         = __reset ? '0 : sel_n;
        xfer        = g_valid && g_ready;
        r0_valid    = streaming && grant_q[0] && g_valid;
        r0_done     = streaming && grant_q[0] && g_done;
        r0_output_0 = (streaming && grant_q[0]) ? g_output_0 : '0;
        r1_valid    = streaming && grant_q[1] && g_valid;
        r1_done     = streaming && grant_q[1] && g_done;
        r1_output_0 = (streaming && grant_q[1]) ? g_output_0 : '0;
        grant       = grant_q;
`ifdef GEN_ARB2_WATCHDOG_EN
        err         = err_q;
`else
        err         = 1'b0;
`endif
    end

    // Next-state logic: arbitration, launch, stream end, abort.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef GEN_ARB2_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (r0_req && r1_req) begin
                    grant_d = last_q ? 2'b01 : 2'b10;
                    state_d = LAUNCH;
                end else if (r0_req) begin
                    grant_d = 2'b01;
                    state_d = LAUNCH;
                end else if (r1_req) begin
                    grant_d = 2'b10;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = sel_req ? STREAM : ABORT;
`ifdef GEN_ARB2_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            STREAM: begin
                // A done transfer takes priority over a dropped request.
                if (xfer && g_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = grant_q[1];
                end else if (!sel_req) begin
                    state_d = ABORT;
`ifdef GEN_ARB2_WATCHDOG_EN
                end else if (wd_q == '1) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
`endif
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = grant_q[1];
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge __clock) begin
        if (__reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
`ifdef GEN_ARB2_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef GEN_ARB2_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_gen_arb2.sv
// tb_gen_arb2: directed bench for gen_arb2 with a Fibonacci generator model.
module tb_gen_arb2;

    logic               clk = 1'b0;
    logic               rst;
    logic               r0_req, r1_req, r0_ready, r1_ready;
    logic signed [31:0] r0_n, r1_n;
    logic               r0_valid, r0_done, r1_valid, r1_done;
    logic signed [31:0] r0_output_0, r1_output_0;
    logic signed [31:0] g_n;
    logic               g_start, g_reset, g_ready, g_valid, g_done;
    logic signed [31:0] g_output_0;
    logic [1:0]         grant;
    logic               err;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    gen_arb2 dut (
        .__clock(clk), .__reset(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_n(r0_n), .r1_n(r1_n),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_valid(r0_valid), .r0_done(r0_done), .r1_valid(r1_valid), .r1_done(r1_done),
        .r0_output_0(r0_output_0), .r1_output_0(r1_output_0),
        .g_n(g_n), .g_start(g_start), .g_reset(g_reset), .g_ready(g_ready),
        .g_valid(g_valid), .g_done(g_done), .g_output_0(g_output_0),
        .grant(grant), .err(err)
    );

    // Fibonacci generator: emits fib(0..n-1), done with the last value.
    logic               gen_act = 1'b0;
    logic               stall = 1'b0;
    logic signed [31:0] gen_a, gen_b, gen_lim;
    int                 gen_cnt;

    always @(posedge clk) begin
        if (g_reset) begin
            gen_act <= 1'b0;
        end else if (g_start) begin
            gen_act <= 1'b1;
            gen_cnt <= 0;
            gen_a   <= 0;
            gen_b   <= 1;
            gen_lim <= g_n;
        end else if (gen_act && g_valid && g_ready) begin
            if (g_done) gen_act <= 1'b0;
            gen_a   <= gen_b;
            gen_b   <= gen_a + gen_b;
            gen_cnt <= gen_cnt + 1;
        end
    end

    assign g_valid    = gen_act && !stall;
    assign g_done     = gen_act && (gen_cnt == gen_lim - 1);
    assign g_output_0 = gen_act ? gen_a : 32'sd0;

    // Per-cycle snapshot taken at the falling edge, plus received streams.
    logic [1:0]         s_grant;
    logic               s_gstart, s_greset, s_gready, s_err, s_r0v;
    logic signed [31:0] s_gn, s_gout;
    int                 q0[$], q1[$];
    logic               done0, done1, bad11 = 1'b0;

    task automatic step();
        @(negedge clk);
        #1;
        s_grant  = grant;
        s_gstart = g_start;
        s_greset = g_reset;
        s_gready = g_ready;
        s_err    = err;
        s_r0v    = r0_valid;
        s_gn     = g_n;
        s_gout   = g_output_0;
        if (grant == 2'b11) bad11 = 1'b1;
        if (r0_valid && r0_ready) begin
            q0.push_back(r0_output_0);
            if (r0_done) done0 = 1'b1;
        end
        if (r1_valid && r1_ready) begin
            q1.push_back(r1_output_0);
            if (r1_done) done1 = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0_req = 0; r1_req = 0; r0_ready = 0; r1_ready = 0; r0_n = 0; r1_n = 0;
        stall = 0;
        rst = 1;
        step();
        step();
        rst = 0;
        q0.delete(); q1.delete();
        done0 = 0; done1 = 0;
    endtask

    task automatic test_reset();
        r0_req = 0; r1_req = 0; r0_ready = 0; r1_ready = 0; r0_n = 0; r1_n = 0;
        done0 = 0; done1 = 0;
        rst = 1;
        step();
        step();
        chk_cnt++; if (s_grant !== 2'b00) begin err_cnt++; $display("FAIL reset_grant got %b want 00", s_grant); end
        chk_cnt++; if (s_greset !== 1'b1) begin err_cnt++; $display("FAIL reset_greset got %b want 1", s_greset); end
        chk_cnt++; if (s_err !== 1'b0) begin err_cnt++; $display("FAIL reset_err got %b want 0", s_err); end
        chk_cnt++; if (s_gstart !== 1'b0 || s_gready !== 1'b0 || s_gn !== 0) begin
            err_cnt++; $display("FAIL reset_gen_outs got start=%b ready=%b n=%0d want 0,0,0", s_gstart, s_gready, s_gn);
        end
        rst = 0;
    endtask

    task automatic test_single();
        int exp0[5] = '{0, 1, 1, 2, 3};
        do_reset();
        r0_req = 1; r0_n = 5; r0_ready = 1;
        step();
        chk_cnt++; if (s_grant !== 2'b00) begin err_cnt++; $display("FAIL single_idle_grant got %b want 00", s_grant); end
        step();
        chk_cnt++; if (s_grant !== 2'b01 || s_gstart !== 1'b1 || s_gready !== 1'b0 || s_gn !== 5) begin
            err_cnt++; $display("FAIL single_launch got grant=%b start=%b ready=%b n=%0d want 01,1,0,5", s_grant, s_gstart, s_gready, s_gn);
        end
        for (int i = 0; i < 40 && !done0; i++) step();
        chk_cnt++; if (!done0) begin err_cnt++; $display("FAIL single_done got 0 want 1 (timeout)"); end
        chk_cnt++; if (q0.size() != 5) begin err_cnt++; $display("FAIL single_count got %0d want 5", q0.size()); end
        for (int i = 0; i < 5 && i < q0.size(); i++) begin
            chk_cnt++; if (q0[i] != exp0[i]) begin err_cnt++; $display("FAIL single_val[%0d] got %0d want %0d", i, q0[i], exp0[i]); end
        end
        r0_req = 0;
        step();
        chk_cnt++; if (s_grant !== 2'b00) begin err_cnt++; $display("FAIL single_end_grant got %b want 00", s_grant); end
    endtask

    task automatic test_both();
        int exp0[3] = '{0, 1, 1};
        int exp1[2] = '{0, 1};
        do_reset();
        bad11 = 0;
        r0_req = 1; r0_n = 3; r0_ready = 1;
        r1_req = 1; r1_n = 2; r1_ready = 1;
        step();
        step();
        chk_cnt++; if (s_grant !== 2'b01 || s_gn !== 3) begin err_cnt++; $display("FAIL both_first_grant got %b n=%0d want 01 n=3", s_grant, s_gn); end
        for (int i = 0; i < 40 && !done0; i++) step();
        chk_cnt++; if (!done0 || q0.size() != 3) begin err_cnt++; $display("FAIL both_r0_count got %0d done=%b want 3 done=1", q0.size(), done0); end
        for (int i = 0; i < 3 && i < q0.size(); i++) begin
            chk_cnt++; if (q0[i] != exp0[i]) begin err_cnt++; $display("FAIL both_r0_val[%0d] got %0d want %0d", i, q0[i], exp0[i]); end
        end
        chk_cnt++; if (q1.size() != 0) begin err_cnt++; $display("FAIL both_r1_early got %0d want 0", q1.size()); end
        r0_req = 0;
        step();
        chk_cnt++; if (s_grant !== 2'b00) begin err_cnt++; $display("FAIL both_gap_grant got %b want 00", s_grant); end
        step();
        chk_cnt++; if (s_grant !== 2'b10 || s_gstart !== 1'b1 || s_gn !== 2) begin
            err_cnt++; $display("FAIL both_second_launch got grant=%b start=%b n=%0d want 10,1,2", s_grant, s_gstart, s_gn);
        end
        for (int i = 0; i < 40 && !done1; i++) step();
        chk_cnt++; if (!done1 || q1.size() != 2) begin err_cnt++; $display("FAIL both_r1_count got %0d done=%b want 2 done=1", q1.size(), done1); end
        for (int i = 0; i < 2 && i < q1.size(); i++) begin
            chk_cnt++; if (q1[i] != exp1[i]) begin err_cnt++; $display("FAIL both_r1_val[%0d] got %0d want %0d", i, q1[i], exp1[i]); end
        end
        r1_req = 0;
        step();
        chk_cnt++; if (bad11) begin err_cnt++; $display("FAIL both_grant11 got 11 want never"); end
    endtask

    task automatic test_backpressure();
        int exp1[6] = '{0, 1, 1, 2, 3, 5};
        logic signed [31:0] held;
        do_reset();
        r1_req = 1; r1_n = 6; r1_ready = 1;
        for (int i = 0; i < 30 && q1.size() < 2; i++) step();
        chk_cnt++; if (q1.size() != 2) begin err_cnt++; $display("FAIL bp_pre_count got %0d want 2", q1.size()); end
        r1_ready = 0;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) held = s_gout;
            chk_cnt++; if (s_gready !== 1'b0) begin err_cnt++; $display("FAIL bp_gready[%0d] got %b want 0", i, s_gready); end
            chk_cnt++; if (s_gout !== held) begin err_cnt++; $display("FAIL bp_hold[%0d] got %0d want %0d", i, s_gout, held); end
        end
        chk_cnt++; if (held !== 1) begin err_cnt++; $display("FAIL bp_held_value got %0d want 1", held); end
        chk_cnt++; if (q1.size() != 2) begin err_cnt++; $display("FAIL bp_stall_count got %0d want 2", q1.size()); end
        r1_ready = 1;
        for (int i = 0; i < 40 && !done1; i++) step();
        chk_cnt++; if (!done1 || q1.size() != 6) begin err_cnt++; $display("FAIL bp_count got %0d done=%b want 6 done=1", q1.size(), done1); end
        for (int i = 0; i < 6 && i < q1.size(); i++) begin
            chk_cnt++; if (q1[i] != exp1[i]) begin err_cnt++; $display("FAIL bp_val[%0d] got %0d want %0d", i, q1[i], exp1[i]); end
        end
        r1_req = 0;
        step();
    endtask

    task automatic test_abort();
        int exp1[2] = '{0, 1};
        do_reset();
        r0_req = 1; r0_n = 10; r0_ready = 1;
        for (int i = 0; i < 30 && q0.size() < 2; i++) step();
        chk_cnt++; if (q0.size() != 2) begin err_cnt++; $display("FAIL abort_pre_count got %0d want 2", q0.size()); end
        r1_req = 1; r1_n = 2; r1_ready = 1;
        r0_req = 0; r0_ready = 0;
        step();
        chk_cnt++; if (s_greset !== 1'b0) begin err_cnt++; $display("FAIL abort_early_greset got %b want 0", s_greset); end
        step();
        chk_cnt++; if (s_greset !== 1'b1 || s_grant !== 2'b01 || s_gstart !== 1'b0) begin
            err_cnt++; $display("FAIL abort_state got greset=%b grant=%b start=%b want 1,01,0", s_greset, s_grant, s_gstart);
        end
        step();
        chk_cnt++; if (s_greset !== 1'b0 || s_grant !== 2'b00) begin
            err_cnt++; $display("FAIL abort_idle got greset=%b grant=%b want 0,00", s_greset, s_grant);
        end
        step();
        chk_cnt++; if (s_grant !== 2'b10 || s_gstart !== 1'b1 || s_gn !== 2) begin
            err_cnt++; $display("FAIL abort_next_launch got grant=%b start=%b n=%0d want 10,1,2", s_grant, s_gstart, s_gn);
        end
        chk_cnt++; if (done0 || q0.size() != 2) begin err_cnt++; $display("FAIL abort_r0_tail got %0d done=%b want 2 done=0", q0.size(), done0); end
        for (int i = 0; i < 40 && !done1; i++) step();
        chk_cnt++; if (!done1 || q1.size() != 2) begin err_cnt++; $display("FAIL abort_r1_count got %0d done=%b want 2 done=1", q1.size(), done1); end
        for (int i = 0; i < 2 && i < q1.size(); i++) begin
            chk_cnt++; if (q1[i] != exp1[i]) begin err_cnt++; $display("FAIL abort_r1_val[%0d] got %0d want %0d", i, q1[i], exp1[i]); end
        end
        r1_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        r0_req = 1; r0_n = 8; r0_ready = 1;
        for (int i = 0; i < 30 && q0.size() < 2; i++) step();
        chk_cnt++; if (q0.size() != 2) begin err_cnt++; $display("FAIL rstmid_pre_count got %0d want 2", q0.size()); end
        rst = 1;
        step();
        chk_cnt++; if (s_greset !== 1'b1 || s_gready !== 1'b0 || s_gn !== 0 || s_gstart !== 1'b0 || s_r0v !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_outs got greset=%b ready=%b n=%0d start=%b r0v=%b want 1,0,0,0,0",
                                s_greset, s_gready, s_gn, s_gstart, s_r0v);
        end
        rst = 0; r0_req = 0;
        step();
        chk_cnt++; if (s_grant !== 2'b00 || s_greset !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_after got grant=%b greset=%b want 00,0", s_grant, s_greset);
        end
        chk_cnt++; if (done0) begin err_cnt++; $display("FAIL rstmid_done got 1 want 0"); end
    endtask

`ifdef GEN_ARB2_WATCHDOG_EN
    task automatic test_watchdog();
        int  cnt;
        logic seen;
        do_reset();
        stall = 1;
        r0_req = 1; r0_n = 3; r0_ready = 1;
        for (int i = 0; i < 5 && !s_gstart; i++) step();
        chk_cnt++; if (!s_gstart) begin err_cnt++; $display("FAIL wd_launch got 0 want 1"); end
        cnt = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (s_greset) seen = 1; else cnt++;
        end
        chk_cnt++; if (!seen) begin err_cnt++; $display("FAIL wd_abort got none want abort (timeout)"); end
        chk_cnt++; if (cnt < 255 || cnt > 256) begin err_cnt++; $display("FAIL wd_cycles got %0d want 255..256", cnt); end
        r0_req = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++; if (s_err !== 1'b1) begin err_cnt++; $display("FAIL wd_err_sticky[%0d] got %b want 1", i, s_err); end
        end
        do_reset();
        chk_cnt++; if (s_err !== 1'b0) begin err_cnt++; $display("FAIL wd_err_clear got %b want 0", s_err); end
    endtask
`else
    task automatic test_no_watchdog();
        int   exp0[3] = '{0, 1, 1};
        logic bad;
        do_reset();
        stall = 1;
        r0_req = 1; r0_n = 3; r0_ready = 1;
        for (int i = 0; i < 5 && !s_gstart; i++) step();
        chk_cnt++; if (!s_gstart) begin err_cnt++; $display("FAIL nowd_launch got 0 want 1"); end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (s_greset || s_grant !== 2'b01 || s_err) bad = 1;
        end
        chk_cnt++; if (bad) begin err_cnt++; $display("FAIL nowd_stall got abort/err want steady stream"); end
        stall = 0;
        for (int i = 0; i < 40 && !done0; i++) step();
        chk_cnt++; if (!done0 || q0.size() != 3) begin err_cnt++; $display("FAIL nowd_count got %0d done=%b want 3 done=1", q0.size(), done0); end
        for (int i = 0; i < 3 && i < q0.size(); i++) begin
            chk_cnt++; if (q0[i] != exp0[i]) begin err_cnt++; $display("FAIL nowd_val[%0d] got %0d want %0d", i, q0[i], exp0[i]); end
        end
        r0_req = 0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_both();
        test_backpressure();
        test_abort();
        test_reset_mid();
`ifdef GEN_ARB2_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule
